// File: rtl/sdp_y_core_chn_out_buf.sv
// sdp_y_core_chn_out_buf
//   Output channel buffer for the SDP Y core datapaths. The core writes
//   results with a load/enable handshake. Results are queued in a DEPTH-entry
//   FIFO and presented downstream on a valid/ready pair, so core stalls and
//   downstream back-pressure are decoupled.
//
// Ports
//   nvdla_core_clk         in   clock, all state updates on the rising edge
//   nvdla_core_rst         in   synchronous active-high reset
//   core_wen               in   core stage enable; writes are ignored while low
//   chn_out_rsci_ld        in   core requests a write this cycle
//   chn_out_rsci_d         in   write payload
//   chn_out_rsci_bawt      out  buffer can accept a write this cycle
//   chn_out_rsci_wen_comp  out  core may proceed (!ld | bawt)
//   chn_out_rsc_z          out  head-of-buffer payload, zero when empty
//   chn_out_rsc_lz         out  downstream valid
//   chn_out_rsc_vz         in   downstream ready
//   chn_out_rsci_cnt       out  registered occupancy
//   chn_out_rsci_afull     out  registered (cnt >= AFULL_LVL)
//
// Handshakes
//   Write side: a word is stored on an edge where ld & core_wen & bawt.
//   If ld is high and bawt is low, the core must hold ld and d.
//   Read side: a word leaves on an edge where lz & vz. Once lz is high, it
//   stays high and z stays stable until that pop happens.
module sdp_y_core_chn_out_buf #(
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 2,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int PASS_READY = 0
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rst,
  input  logic                       core_wen,
  input  logic                       chn_out_rsci_ld,
  input  logic [WIDTH-1:0]           chn_out_rsci_d,
  output logic                       chn_out_rsci_bawt,
  output logic                       chn_out_rsci_wen_comp,
  output logic [WIDTH-1:0]           chn_out_rsc_z,
  output logic                       chn_out_rsc_lz,
  input  logic                       chn_out_rsc_vz,
  output logic [$clog2(DEPTH+1)-1:0] chn_out_rsci_cnt,
  output logic                       chn_out_rsci_afull
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The storage array is deliberately not reset. The pointers and the count
  // define which entries are valid.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_afull;

  logic             w_lz;
  logic             w_pop;
  logic             w_push;
  logic             w_bawt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  assign w_lz  = (r_cnt != '0);
  assign w_pop = w_lz & chn_out_rsc_vz;

  // With PASS_READY a full buffer can take a word in the same cycle as the
  // head leaves. This creates a combinational path from vz to bawt.
  assign w_bawt = (r_cnt != CW'(DEPTH)) | ((PASS_READY != 0) & w_pop);
  assign w_push = chn_out_rsci_ld & core_wen & w_bawt;

  // Pointers wrap at DEPTH, which need not be a power of two.
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_afull  <= (AFULL_LVL == 0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_cnt   <= w_cnt_nxt;
      r_afull <= (w_cnt_nxt >= CW'(AFULL_LVL));
    end
  end

  // Data write. A write during reset is harmless because the pointers and
  // the count are cleared in the same cycle.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= chn_out_rsci_d;
    end
  end

  assign chn_out_rsci_bawt     = w_bawt;
  assign chn_out_rsci_wen_comp = ~chn_out_rsci_ld | w_bawt;
  assign chn_out_rsc_lz        = w_lz;
  assign chn_out_rsc_z         = w_lz ? r_mem[r_rd_ptr] : '0;
  assign chn_out_rsci_cnt      = r_cnt;
  assign chn_out_rsci_afull    = r_afull;

endmodule

// File: tb/tb_sdp_y_core_chn_out_buf.sv
// Testbench for sdp_y_core_chn_out_buf.
// Five instances with different DEPTH/PASS_READY settings share one stimulus
// stream. Each instance has its own queue model that predicts every output.
//   u0: DEPTH=4 PR=0   u1: DEPTH=2 PR=0   u2: DEPTH=2 PR=1
//   u3: DEPTH=3 PR=0   u4: DEPTH=1 PR=1   (all WIDTH=128, AFULL_LVL=DEPTH-1)
module tb_sdp_y_core_chn_out_buf;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wen = 1'b0;
  logic         ld  = 1'b0;
  logic         vz  = 1'b0;
  logic [W-1:0] d   = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Checks happen on the
  // falling edge.
  task automatic drive(input logic r, input logic l, input logic w, input logic v,
                       input logic [W-1:0] dd);
    @(posedge clk);
    #1;
    rst = r; ld = l; wen = w; vz = v; d = dd;
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_inst
    localparam int D  = (g == 0) ? 4 : (g == 3) ? 3 : (g == 4) ? 1 : 2;
    localparam int PR = (g == 2 || g == 4) ? 1 : 0;
    localparam int AF = D - 1;
    localparam int CW = $clog2(D + 1);

    logic          bawt, wen_comp, lz, afull;
    logic [W-1:0]  z;
    logic [CW-1:0] cnt;
    logic [W-1:0]  exp_q[$];

    sdp_y_core_chn_out_buf #(
      .WIDTH(W), .DEPTH(D), .AFULL_LVL(AF), .PASS_READY(PR)
    ) u_dut (
      .nvdla_core_clk       (clk),
      .nvdla_core_rst       (rst),
      .core_wen             (wen),
      .chn_out_rsci_ld      (ld),
      .chn_out_rsci_d       (d),
      .chn_out_rsci_bawt    (bawt),
      .chn_out_rsci_wen_comp(wen_comp),
      .chn_out_rsc_z        (z),
      .chn_out_rsc_lz       (lz),
      .chn_out_rsc_vz       (vz),
      .chn_out_rsci_cnt     (cnt),
      .chn_out_rsci_afull   (afull)
    );

    // Predict the outputs from the queue contents and the current inputs.
    always @(negedge clk) begin : p_check
      int   n;
      logic e_pop, e_bawt;
      n      = exp_q.size();
      e_pop  = (n != 0) && vz;
      e_bawt = (n != D) || (PR == 1 && e_pop);
      chk($sformatf("u%0d.cnt", g),      W'(cnt),      W'(n));
      chk($sformatf("u%0d.lz", g),       W'(lz),       W'(n != 0));
      chk($sformatf("u%0d.z", g),        z,            (n != 0) ? exp_q[0] : '0);
      chk($sformatf("u%0d.afull", g),    W'(afull),    W'(n >= AF));
      chk($sformatf("u%0d.bawt", g),     W'(bawt),     W'(e_bawt));
      chk($sformatf("u%0d.wen_comp", g), W'(wen_comp), W'(!ld || e_bawt));
    end

    // Advance the model: reset empties it; otherwise pop the head when
    // valid & ready, and append the word when ld & wen & room.
    always @(posedge clk) begin : p_model
      logic m_pop, m_room;
      if (rst) begin
        exp_q.delete();
      end else begin
        m_pop  = (exp_q.size() != 0) && vz;
        m_room = (exp_q.size() != D) || (PR == 1 && m_pop);
        if (m_pop) void'(exp_q.pop_front());
        if (ld && wen && m_room) exp_q.push_back(d);
      end
    end
  end

  initial begin
    logic [W-1:0] rnd;
    // Reset, then idle.
    drive(1, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);

    // Fill with vz=0, attempt a fifth write, then drain.
    drive(0, 1, 1, 0, W'(8'h11));
    drive(0, 1, 1, 0, W'(8'h22));
    drive(0, 1, 1, 0, W'(8'h33));
    drive(0, 1, 1, 0, W'(8'h44));
    drive(0, 1, 1, 0, W'(8'h55));
    drive(0, 1, 1, 0, W'(8'h55));
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 1, '0);

    // Full buffer with write and pop in the same cycle, then hold the write.
    drive(0, 1, 1, 0, W'(8'ha1));
    drive(0, 1, 1, 0, W'(8'ha2));
    drive(0, 1, 1, 1, W'(8'ha3));
    drive(0, 1, 1, 0, W'(8'ha3));
    drive(0, 0, 1, 0, '0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, '0);

    // ld with core_wen low is ignored.
    drive(0, 1, 0, 0, W'(8'hee));
    drive(0, 1, 0, 1, W'(8'hef));
    drive(0, 0, 1, 1, '0);

    // Reset while two entries are queued; push and pop in the reset cycle.
    drive(0, 1, 1, 0, W'(8'hb1));
    drive(0, 1, 1, 0, W'(8'hb2));
    drive(1, 1, 1, 1, W'(8'hb3));
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), rnd);
    end
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 1, '0);

    // Continuous streaming with an incrementing payload.
    for (int i = 1; i <= 24; i++) drive(0, 1, 1, 1, W'(i));
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 1, '0);

    drive(0, 0, 0, 0, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
